seq_shifter: RTL and testbench

- Iterative, clocked counterpart of the team's combinational 8-bit shift/rotate unit.
- Accepts the same 4-bit op encoding (mode + amount) and performs the operation one bit position per clock.
- An `inverse` input swaps the direction of the operation. Feeding a rotate result back with `inverse=1` recovers the original data, so the block acts as the decoder for the combinational unit's rotate output.
- Sits between the board switch/button front end and the LED/display path, with a start/busy/done handshake.

---
 rtl/shifter_pkg.sv | 21 ++
 rtl/shift_step_1.sv | 24 ++
 rtl/seq_shifter.sv | 90 +++++++++
 tb/tb_seq_shifter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared encodings for the iterative shift/rotate unit: mode codes, FSM states
// and the direction-swap helper used when decoding rotate results.
package shifter_pkg;

    localparam logic [1:0] MODE_SHL = 2'b00;
    localparam logic [1:0] MODE_SHR = 2'b01;
    localparam logic [1:0] MODE_ROL = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Toggling bit 0 swaps SHL<->SHR and ROL<->ROR.
    function automatic logic [1:0] invert_mode(input logic [1:0] mode);
        return {mode[1], ~mode[0]};
    endfunction

endpackage

// File: rtl/shift_step_1.sv
// Combinational single-position shift/rotate step; shifts zero-fill,
// rotates wrap the outgoing bit around.
import shifter_pkg::*;

module shift_step_1 #(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] next_r
);

    always_comb begin
        next_r = r;
        case (mode)
            MODE_SHL: next_r = {r[WIDTH-2:0], 1'b0};
            MODE_SHR: next_r = {1'b0, r[WIDTH-1:1]};
            MODE_ROL: next_r = {r[WIDTH-2:0], r[WIDTH-1]};
            MODE_ROR: next_r = {r[0], r[WIDTH-1:1]};
            default:  next_r = r;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Iterative shift/rotate unit: one bit position per clock with a
// start/busy/done handshake; dout holds the last result until the next done.
import shifter_pkg::*;

module seq_shifter #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [AMT_W+1:0]   op,
    input  logic               inverse,
    input  logic [WIDTH-1:0]   din,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   dout
);

    localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [1:0]       mode;
    logic [AMT_W-1:0] cnt;
    logic [WIDTH-1:0] step_r;
    logic [1:0]       op_mode;
    logic [AMT_W-1:0] op_amt;

    assign op_mode = op[AMT_W+1:AMT_W];
    assign op_amt  = op[AMT_W-1:0];

    shift_step_1 #(.WIDTH(WIDTH)) u_step (
        .mode   (mode),
        .r      (work),
        .next_r (step_r)
    );

    // busy and done are registered alongside the state so they track it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            work  <= '0;
            mode  <= MODE_SHL;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dout  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        work <= din;
                        mode <= inverse ? invert_mode(op_mode) : op_mode;
                        cnt  <= op_amt;
                        busy <= 1'b1;
                        if (op_amt == '0) begin
                            state <= ST_DONE;
                            dout  <= din;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    work <= step_r;
                    cnt  <= cnt - AMT_ONE;
                    if (cnt == AMT_ONE) begin
                        state <= ST_DONE;
                        dout  <= step_r;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: stimulus pushes expected result and done
// cycle; a negedge monitor pops and compares on every done pulse.
module tb_seq_shifter;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] op;
    logic       inverse;
    logic [7:0] din;
    logic       busy;
    logic       done;
    logic [7:0] dout;

    typedef struct {
        logic [7:0] data;
        int         cycle;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   done_count = 0;

    seq_shifter #(.WIDTH(8), .AMT_W(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .inverse (inverse),
        .din     (din),
        .busy    (busy),
        .done    (done),
        .dout    (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_count++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("dout", {24'd0, dout}, {24'd0, e.data});
                checkOutput("done_cycle", cyc, e.cycle);
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] o, input logic inv, input logic [7:0] d,
                                 input logic [7:0] exp, input bit track);
        exp_t e;
        @(negedge clk);
        op      = o;
        inverse = inv;
        din     = d;
        start   = 1'b1;
        @(posedge clk);
        #1;
        if (track) begin
            e.data  = exp;
            e.cycle = cyc + int'(o[1:0]);
            sb.push_back(e);
        end
        start   = 1'b0;
        op      = 4'($urandom);
        inverse = 1'($urandom);
        din     = 8'($urandom);
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_idle_timeout", 32'(n < 50), 32'd1);
    endtask

    initial begin
        int bc;
        int dc;

        rst_n   = 1'b0;
        start   = 1'($urandom);
        op      = 4'($urandom);
        inverse = 1'($urandom);
        din     = 8'($urandom);
        #2;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_dout", {24'd0, dout}, 32'h00);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // ROR 3, with busy-cycle count
        applyStimulus(4'hF, 1'b0, 8'h96, 8'hD2, 1'b1);
        bc = 0;
        @(negedge clk);
        while (busy && bc < 20) begin
            bc++;
            @(negedge clk);
        end
        checkOutput("ror3_busy_cycles", bc, 32'd4);
        waitIdle();

        // Inverse round trip; previous result stays visible meanwhile
        applyStimulus(4'hF, 1'b1, 8'hD2, 8'h96, 1'b1);
        checkOutput("dout_held", {24'd0, dout}, 32'hD2);
        waitIdle();

        applyStimulus(4'h9, 1'b0, 8'h96, 8'h2D, 1'b1);
        waitIdle();
        applyStimulus(4'h3, 1'b0, 8'hFF, 8'hF8, 1'b1);
        waitIdle();
        applyStimulus(4'h6, 1'b0, 8'h81, 8'h20, 1'b1);
        waitIdle();
        applyStimulus(4'h6, 1'b1, 8'h81, 8'h04, 1'b1);
        waitIdle();
        applyStimulus(4'h4, 1'b0, 8'h5A, 8'h5A, 1'b1);
        waitIdle();

        // Start while busy must be ignored
        dc = done_count;
        applyStimulus(4'h3, 1'b0, 8'h01, 8'h08, 1'b1);
        @(negedge clk);
        start = 1'b1;
        din   = 8'hFF;
        op    = 4'h4;
        @(negedge clk);
        start = 1'b0;
        waitIdle();
        repeat (6) @(negedge clk);
        checkOutput("single_done", done_count - dc, 32'd1);
        checkOutput("dout_after_ignore", {24'd0, dout}, 32'h08);

        // Reset abort mid-shift
        dc = done_count;
        applyStimulus(4'h7, 1'b0, 8'hF0, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("abort_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        checkOutput("abort_dout", {24'd0, dout}, 32'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("abort_no_done", done_count - dc, 32'd0);

        applyStimulus(4'hB, 1'b0, 8'h81, 8'h0C, 1'b1);
        waitIdle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
